// File: rtl/mem_if_pkg.sv
// Shared memory-interface definitions: FSM state encoding, word geometry,
// the captured request payload and an alignment helper.
package mem_if_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned OFS_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Request payload as captured at acceptance.
    typedef struct packed {
        logic              write;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
    } mem_req_t;

    // A word access is misaligned when any byte-offset bit is set.
    function automatic logic is_misaligned(input logic [WORD_W-1:0] addr);
        return addr[OFS_W-1:0] != '0;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word RAM: synchronous write, combinational read.
// Ports: clk; we write enable; idx word index; wdata write data;
//        rdata read data at idx.
module dmem_array
    import mem_if_pkg::*;
#(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    // Storage is never reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
    end

    assign rdata = mem_q[idx];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM-stage load/store port.
// Accepts a request in IDLE, waits LATENCY cycles, then pulses resp_valid
// for one cycle carrying load data and a misalignment flag.
// Ports: clk, rst (async active-high); req_valid/req_write/req_addr/req_wdata
//        request side; req_ready high in IDLE; resp_valid/resp_rdata/resp_err
//        response side; stall asks the pipeline to freeze while a request
//        is outstanding.
module dmem_responder
    import mem_if_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              stall
);

    localparam int unsigned CNT_W = 4;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    mem_req_t          req_q, req_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [WORD_W-1:0] resp_rdata_q, resp_rdata_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_idx;
    logic [WORD_W-1:0] mem_rdata;

    // Next-state, counter and request capture.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        req_d   = req_q;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    req_d.write = req_write;
                    req_d.addr  = req_addr;
                    req_d.wdata = req_wdata;
                    count_d     = CNT_W'(LATENCY - 1);
                    state_d     = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                // Misaligned stores are dropped.
                mem_we  = req_q.write & ~is_misaligned(req_q.addr);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // req_d holds the live request in IDLE and the captured one afterwards,
    // so one index serves both the pre-response read and the RESP write.
    assign mem_idx = req_d.addr[ADDR_W+OFS_W-1:OFS_W];

    // Registered outputs, computed for the state being entered. Memory only
    // changes in RESP, so reading it on entry matches reading it in RESP.
    always_comb begin
        req_ready_d  = (state_d == ST_IDLE);
        resp_valid_d = (state_d == ST_RESP);
        resp_err_d   = resp_valid_d & is_misaligned(req_d.addr);
        resp_rdata_d = '0;
        if (resp_valid_d && !req_d.write && !resp_err_d) begin
            resp_rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            req_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            req_q        <= req_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    dmem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .idx   (mem_idx),
        .wdata (req_q.wdata),
        .rdata (mem_rdata)
    );

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    // Held high by a pending request until the response cycle.
    assign stall      = req_valid & ~resp_valid_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Three responders (LATENCY 1, 2, 5) driven one at a time. Expected responses
// are queued per lane at issue time and checked by per-lane monitors.
module tb_dmem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_write;
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [2:0]  req_ready;
    logic [2:0]  resp_valid;
    logic [31:0] resp_rdata [3];
    logic [2:0]  resp_err;
    logic [2:0]  stall;

    exp_t        exp_q [3][$];
    logic [31:0] ref_mem [3][256];
    int          n_checks = 0;
    int          n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int l);
        return (l == 0) ? 1 : (l == 1) ? 2 : 5;
    endfunction

    task automatic check(input string name, input int l,
                         input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s lane%0d actual=%h required=%h t=%0t",
                     name, l, act, req, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_lane
        localparam int unsigned LAT = (g == 0) ? 1 : (g == 1) ? 2 : 5;

        dmem_responder #(
            .DEPTH   (256),
            .ADDR_W  (8),
            .LATENCY (LAT)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid[g]),
            .req_write  (req_write[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .req_ready  (req_ready[g]),
            .resp_valid (resp_valid[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_err   (resp_err[g]),
            .stall      (stall[g])
        );

        // Scoreboard monitor: every response must match the oldest expectation.
        always @(negedge clk) begin
            if (resp_valid[g] === 1'b1) begin
                if (exp_q[g].size() == 0) begin
                    check("resp_unexpected", g, 32'(resp_valid[g]), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q[g].pop_front();
                    check("resp_rdata", g, resp_rdata[g], e.rdata);
                    check("resp_err", g, 32'(resp_err[g]), 32'(e.err));
                end
            end
        end
    end

    // Issue one access, record the reference result and check handshake timing.
    task automatic access(input int l, input bit wr,
                          input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int   k;
        bit   ok;
        e.err   = (a[1:0] != 2'b00);
        e.rdata = (wr || e.err) ? 32'd0 : ref_mem[l][a[9:2]];
        if (wr && !e.err) ref_mem[l][a[9:2]] = wd;
        exp_q[l].push_back(e);
        @(negedge clk);
        req_valid[l] = 1'b1;
        req_write[l] = wr;
        req_addr[l]  = a;
        req_wdata[l] = wd;
        #1;
        check("ready_idle", l, 32'(req_ready[l]), 32'd1);
        check("stall_accept", l, 32'(stall[l]), 32'd1);
        @(posedge clk);
        k  = 0;
        ok = 1'b1;
        do begin
            @(negedge clk);
            k++;
            if (resp_valid[l] !== 1'b1) begin
                if (req_ready[l] !== 1'b0 || stall[l] !== 1'b1) ok = 1'b0;
            end
        end while (resp_valid[l] !== 1'b1 && k < 20);
        check("latency", l, 32'(k), 32'(lat_of(l)));
        check("wait_ready_stall", l, 32'(ok), 32'd1);
        check("stall_resp", l, 32'(stall[l]), 32'd0);
        req_valid[l] = 1'b0;
    endtask

    // Three loads with req_valid never dropped between them.
    task automatic back_to_back(input int l);
        logic [31:0] a [3];
        int   rc [3];
        int   n, cyc;
        bit   prev_resp, ok;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            a[i]    = 32'($urandom_range(255)) << 2;
            e.rdata = ref_mem[l][a[i][9:2]];
            e.err   = 1'b0;
            exp_q[l].push_back(e);
            rc[i]   = 0;
        end
        @(negedge clk);
        req_valid[l] = 1'b1;
        req_write[l] = 1'b0;
        req_addr[l]  = a[0];
        n = 0; cyc = 0; prev_resp = 1'b0; ok = 1'b1;
        while (n < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            // Ready is high exactly in the IDLE cycle following a response.
            if (req_ready[l] !== prev_resp) ok = 1'b0;
            prev_resp = (resp_valid[l] === 1'b1);
            if (prev_resp) begin
                rc[n] = cyc;
                n++;
                if (n < 3) req_addr[l] = a[n];
                else       req_valid[l] = 1'b0;
            end
        end
        check("b2b_count", l, 32'(n), 32'd3);
        check("b2b_first", l, 32'(rc[0]), 32'(lat_of(l)));
        check("b2b_gap1", l, 32'(rc[1] - rc[0]), 32'(lat_of(l) + 1));
        check("b2b_gap2", l, 32'(rc[2] - rc[1]), 32'(lat_of(l) + 1));
        check("b2b_ready", l, 32'(ok), 32'd1);
        @(negedge clk);
        check("b2b_idle_after", l, 32'(req_ready[l]), 32'd1);
    endtask

    // Reset during WAIT of a store on the LATENCY=5 lane.
    task automatic reset_mid_wait();
        bit quiet;
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_write[2] = 1'b1;
        req_addr[2]  = 32'h20;
        req_wdata[2] = 32'hFFFF;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        check("rst_pre_wait_ready", 2, 32'(req_ready[2]), 32'd0);
        rst = 1'b1;
        #1;
        check("rst_resp_valid", 2, 32'(resp_valid[2]), 32'd0);
        check("rst_ready", 2, 32'(req_ready[2]), 32'd1);
        req_valid[2] = 1'b0;
        #1;
        check("rst_stall", 2, 32'(stall[2]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (resp_valid[2] !== 1'b0 || req_ready[2] !== 1'b1) quiet = 1'b0;
        end
        check("rst_no_resp", 2, 32'(quiet), 32'd1);
        access(2, 1'b0, 32'h20, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog lane0 actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        rst       = 1'b1;
        req_valid = '0;
        req_write = '0;
        for (int l = 0; l < 3; l++) begin
            req_addr[l]  = '0;
            req_wdata[l] = '0;
        end
        repeat (2) @(negedge clk);
        for (int l = 0; l < 3; l++) begin
            check("reset_resp_valid", l, 32'(resp_valid[l]), 32'd0);
            check("reset_rdata", l, resp_rdata[l], 32'd0);
            check("reset_err", l, 32'(resp_err[l]), 32'd0);
            check("reset_ready", l, 32'(req_ready[l]), 32'd1);
            check("reset_stall", l, 32'(stall[l]), 32'd0);
        end
        rst = 1'b0;

        // Give every word a known value on every lane.
        for (int l = 0; l < 3; l++)
            for (int i = 0; i < 256; i++)
                access(l, 1'b1, 32'(i) << 2, $urandom);

        // Store/load round trip.
        access(1, 1'b1, 32'h10, 32'hDEADBEEF);
        access(1, 1'b0, 32'h10, 32'd0);
        // Latency 1 and 5 loads of a pre-written word.
        for (int l = 0; l < 3; l += 2) begin
            access(l, 1'b1, 32'h0, 32'h1234);
            access(l, 1'b0, 32'h0, 32'd0);
        end
        // Misaligned store and load, then confirm word 1 untouched.
        for (int l = 0; l < 3; l++) begin
            access(l, 1'b1, 32'h7, 32'hCAFE);
            access(l, 1'b0, 32'h5, 32'd0);
            access(l, 1'b0, 32'h4, 32'd0);
        end
        // Address wrap modulo 1 KiB.
        access(1, 1'b1, 32'h400, 32'h55);
        access(1, 1'b0, 32'h0, 32'd0);

        reset_mid_wait();
        back_to_back(1);
        back_to_back(0);
        back_to_back(2);

        // Random mix with full 32-bit addresses and occasional misalignment.
        for (int n = 0; n < 300; n++) begin
            int l;
            l = int'($urandom_range(2));
            a = $urandom;
            if ($urandom_range(3) != 0) a[1:0] = 2'b00;
            access(l, 1'($urandom_range(1)), a, $urandom);
        end

        repeat (4) @(negedge clk);
        for (int l = 0; l < 3; l++)
            check("queue_drained", l, 32'(exp_q[l].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
